// File: rtl/bam_mul_scheduler.sv
// Round-robin front end for one shared combinational BAM multiplier.
// Grants one requester, drives the operands, captures and returns the product.
module bam_mul_scheduler #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int ID_W  = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   output logic [WIDTH-1:0]       mul_a,
   output logic [WIDTH-1:0]       mul_b,
   input  logic [2*WIDTH-1:0]     mul_p,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [ID_W-1:0]        resp_id,
   output logic [2*WIDTH-1:0]     resp_p,
   output logic                   busy,
   output logic [15:0]            op_count
);

   if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
      $error("bam_mul_scheduler: N_REQ must be 2..8");
   end
   if (ID_W != $clog2(N_REQ)) begin : g_bad_idw
      $error("bam_mul_scheduler: ID_W must equal clog2(N_REQ)");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [ID_W-1:0]      ptr_q, ptr_d;
   logic [ID_W-1:0]      id_q, id_d;
   logic [WIDTH-1:0]     mul_a_q, mul_a_d;
   logic [WIDTH-1:0]     mul_b_q, mul_b_d;
   logic [2*WIDTH-1:0]   resp_p_q, resp_p_d;
   logic [ID_W-1:0]      resp_id_q, resp_id_d;
   logic [15:0]          op_count_q, op_count_d;

   logic                 gnt_found;
   logic [ID_W-1:0]      gnt_idx;
   logic [ID_W-1:0]      cand;

   // Rotating priority search: first valid requester at or after ptr, wrapping
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (int'(ptr_q) + k >= N_REQ) begin
            cand = ID_W'(int'(ptr_q) + k - N_REQ);
         end else begin
            cand = ID_W'(int'(ptr_q) + k);
         end
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   // Next-state, datapath capture and handshake outputs
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      id_d       = id_q;
      mul_a_d    = mul_a_q;
      mul_b_d    = mul_b_q;
      resp_p_d   = resp_p_q;
      resp_id_d  = resp_id_q;
      op_count_d = op_count_q;
      req_ready  = '0;
      unique case (state_q)
         IDLE: begin
            // A granted requester is valid by construction, so grant == handshake
            if (gnt_found && rst_n) begin
               req_ready[gnt_idx] = 1'b1;
               mul_a_d = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
               mul_b_d = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
               id_d    = gnt_idx;
               if (gnt_idx == ID_W'(N_REQ - 1)) begin
                  ptr_d = '0;
               end else begin
                  ptr_d = gnt_idx + ID_W'(1);
               end
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            // Operands have been stable for a full cycle; sample the product
            resp_p_d  = mul_p;
            resp_id_d = id_q;
            state_d   = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               if (op_count_q != 16'hFFFF) begin
                  op_count_d = op_count_q + 16'd1;
               end
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset drops any in-flight operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         id_q       <= '0;
         mul_a_q    <= '0;
         mul_b_q    <= '0;
         resp_p_q   <= '0;
         resp_id_q  <= '0;
         op_count_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         id_q       <= id_d;
         mul_a_q    <= mul_a_d;
         mul_b_q    <= mul_b_d;
         resp_p_q   <= resp_p_d;
         resp_id_q  <= resp_id_d;
         op_count_q <= op_count_d;
      end
   end

   assign mul_a      = mul_a_q;
   assign mul_b      = mul_b_q;
   assign resp_p     = resp_p_q;
   assign resp_id    = resp_id_q;
   assign op_count   = op_count_q;
   assign resp_valid = (state_q == RESP);
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_bam_mul_scheduler.sv
// Bench for bam_mul_scheduler: directed vectors, queue scoreboard,
// exact or h2_v9 BAM multiplier model on mul_p.
module tb_bam_mul_scheduler;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [7:0]  mul_a;
   logic [7:0]  mul_b;
   logic [15:0] mul_p;
   logic        resp_valid;
   logic        resp_ready;
   logic [1:0]  resp_id;
   logic [15:0] resp_p;
   logic        busy;
   logic [15:0] op_count;

   logic        use_bam;
   int          n_cmp;
   int          n_bad;
   logic [17:0] exp_q[$];
   logic [17:0] mon_e;

   bam_mul_scheduler #(.N_REQ(4), .WIDTH(8), .ID_W(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_p      (mul_p),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_p     (resp_p),
      .busy       (busy),
      .op_count   (op_count)
   );

   // Broken-array multiplier, h=2 (rows below 2 dropped), v=9 (i+j<9 dropped)
   function automatic logic [15:0] bam(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] s;
      s = '0;
      for (int i = 2; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            if (i + j >= 9 && a[j] && b[i]) s = s + (16'd1 << (i + j));
         end
      end
      return s;
   endfunction

   assign mul_p = use_bam ? bam(mul_a, mul_b) : ({8'd0, mul_a} * {8'd0, mul_b});

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_opnd(input logic [1:0] id, input logic [7:0] a, input logic [7:0] b);
      req_a[int'(id)*8 +: 8] = a;
      req_b[int'(id)*8 +: 8] = b;
   endtask

   task automatic await_grant(input logic [3:0] exp);
      int w;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (req_ready == 4'd0 && w < 20);
      chk("grant", {28'd0, req_ready}, {28'd0, exp});
   endtask

   task automatic await_idle();
      int w;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while ((busy || resp_valid) && w < 20);
      chk("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   task automatic single_op(input logic [1:0] id, input logic [7:0] a,
                            input logic [7:0] b, input logic [15:0] p);
      @(posedge clk); #1;
      set_opnd(id, a, b);
      req_valid[id] = 1'b1;
      await_grant(4'd1 << id);
      exp_q.push_back({id, p});
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      await_idle();
   endtask

   task automatic chk_reset_vals();
      chk("rst_mul_a", {24'd0, mul_a}, 32'd0);
      chk("rst_mul_b", {24'd0, mul_b}, 32'd0);
      chk("rst_resp_p", {16'd0, resp_p}, 32'd0);
      chk("rst_resp_id", {30'd0, resp_id}, 32'd0);
      chk("rst_op_count", {16'd0, op_count}, 32'd0);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
   endtask

   // Scoreboard monitor: every accepted response must match the queue head
   always @(negedge clk) begin
      if (rst_n && resp_valid && resp_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_resp: got id %0d p 0x%0h with nothing expected at %0t",
                     resp_id, resp_p, $time);
         end else begin
            mon_e = exp_q.pop_front();
            chk("resp_id", {30'd0, resp_id}, {30'd0, mon_e[17:16]});
            chk("resp_p", {16'd0, resp_p}, {16'd0, mon_e[15:0]});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int order [5];
      int prod [4];
      int cyc;
      int last;
      int w;
      order = '{0, 1, 2, 3, 0};
      prod  = '{20, 33, 48, 65};
      n_cmp = 0;
      n_bad = 0;
      use_bam = 1'b0;
      rst_n = 1'b1;
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      resp_ready = 1'b1;

      // Reset with all requests up: nothing may be granted
      #2 rst_n = 1'b0;
      req_valid = 4'b1111;
      #1 chk_reset_vals();
      @(posedge clk); #1;
      req_valid = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Single request, exact multiplier, latency check
      @(posedge clk); #1;
      set_opnd(2'd1, 8'd3, 8'd5);
      req_valid = 4'b0010;
      await_grant(4'b0010);
      exp_q.push_back({2'd1, 16'd15});
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      chk("t1_mul_a", {24'd0, mul_a}, 32'd3);
      chk("t1_mul_b", {24'd0, mul_b}, 32'd5);
      chk("t1_valid_early", {31'd0, resp_valid}, 32'd0);
      chk("t1_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("t1_resp_valid", {31'd0, resp_valid}, 32'd1);
      await_idle();
      chk("t1_op_count", {16'd0, op_count}, 32'd1);

      // Real BAM h2_v9 attached
      use_bam = 1'b1;
      single_op(2'd0, 8'h0F, 8'h0F, 16'h0000);
      single_op(2'd3, 8'h80, 8'h80, 16'h4000);
      use_bam = 1'b0;

      // All four held valid: 0,1,2,3,0 at 3-cycle spacing
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) set_opnd(2'(i), 8'(i + 2), 8'(i + 10));
      req_valid = 4'b1111;
      cyc = 0;
      last = 0;
      for (int k = 0; k < 5; k++) begin
         w = 0;
         do begin
            @(negedge clk);
            cyc++;
            w++;
         end while (req_ready == 4'd0 && w < 10);
         chk("rr_grant", {28'd0, req_ready}, 32'd1 << order[k]);
         exp_q.push_back({2'(order[k]), 16'(prod[order[k]])});
         if (k > 0) chk("rr_gap", cyc - last, 32'd3);
         last = cyc;
      end
      @(posedge clk); #1;
      req_valid = '0;
      await_idle();
      chk("rr_op_count", {16'd0, op_count}, 32'd8);

      // Backpressure for 5 RESP cycles while another request waits
      @(posedge clk); #1;
      resp_ready = 1'b0;
      set_opnd(2'd2, 8'd7, 8'd9);
      req_valid = 4'b0100;
      await_grant(4'b0100);
      exp_q.push_back({2'd2, 16'd63});
      @(posedge clk); #1;
      set_opnd(2'd1, 8'd1, 8'd1);
      req_valid = 4'b0010;
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
         chk("bp_resp_p", {16'd0, resp_p}, 32'd63);
         chk("bp_resp_id", {30'd0, resp_id}, 32'd2);
         chk("bp_busy", {31'd0, busy}, 32'd1);
         chk("bp_req_ready", {28'd0, req_ready}, 32'd0);
      end
      @(posedge clk); #1;
      resp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_resp", {31'd0, resp_valid}, 32'd1);
      @(negedge clk);
      chk("bp_idle_busy", {31'd0, busy}, 32'd0);
      chk("bp_next_grant", {28'd0, req_ready}, 32'b0010);
      exp_q.push_back({2'd1, 16'd1});
      @(posedge clk); #1;
      req_valid = '0;
      await_idle();
      chk("bp_op_count", {16'd0, op_count}, 32'd10);

      // Async reset in ISSUE: drop op, ptr back to 0
      @(posedge clk); #1;
      set_opnd(2'd2, 8'd4, 8'd4);
      req_valid = 4'b0100;
      await_grant(4'b0100);
      @(posedge clk); #1;
      set_opnd(2'd2, 8'd6, 8'd7);
      set_opnd(2'd3, 8'd8, 8'd9);
      req_valid = 4'b1100;
      chk("ar_in_issue", {31'd0, busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals();
      @(posedge clk); #1;
      rst_n = 1'b1;
      await_grant(4'b0100);
      exp_q.push_back({2'd2, 16'd42});
      await_grant(4'b1000);
      exp_q.push_back({2'd3, 16'd72});
      @(posedge clk); #1;
      req_valid = '0;
      await_idle();
      chk("ar_op_count", {16'd0, op_count}, 32'd2);

      // Saturation of op_count
      force dut.op_count_q = 16'hFFFE;
      @(posedge clk); #1;
      release dut.op_count_q;
      @(negedge clk);
      chk("sat_preload", {16'd0, op_count}, 32'hFFFE);
      single_op(2'd2, 8'd1, 8'd2, 16'd2);
      chk("sat_1", {16'd0, op_count}, 32'hFFFF);
      single_op(2'd0, 8'd3, 8'd3, 16'd9);
      chk("sat_2", {16'd0, op_count}, 32'hFFFF);
      single_op(2'd1, 8'd2, 8'd8, 16'd16);
      chk("sat_3", {16'd0, op_count}, 32'hFFFF);

      repeat (4) @(negedge clk);
      chk("sb_drain", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
